// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell adds two WIDTH-bit operands LSB-first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds port i_sub).

module full_adder (
  input  logic i_x,
  input  logic i_y,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_x ^ i_y ^ i_carry;
  assign o_carry = (i_x & i_y) | (i_x & i_carry) | (i_y & i_carry);
endmodule

// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// Operands transfer on i_valid & o_ready; results transfer on o_valid & i_ready.
// o_valid and the result stay stable until the result transfers.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             y_bit;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             cin_load;

  assign accept = (state == IDLE) && i_valid;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  // Subtraction is X + ~Y + 1: invert each Y bit and force the initial carry.
  assign y_bit    = y_sh[0] ^ sub_q;
  assign cin_load = i_carry | i_sub;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= i_sub;
    end
  end
`else
  assign y_bit    = y_sh[0];
  assign cin_load = i_carry;
`endif

  full_adder fa (
    .i_x     (x_sh[0]),
    .i_y     (y_bit),
    .i_carry (c_reg),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  always_comb begin
    s_next            = s_sh >> 1;
    s_next[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_valid)     state_next = CALC;
      CALC:    if (cnt == LAST) state_next = DONE;
      DONE:    if (i_ready)     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state)
      IDLE:    o_ready = 1'b1;
      CALC:    o_busy  = 1'b1;
      DONE:    begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
      end
      default: o_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_sh      <= '0;
      y_sh      <= '0;
      s_sh      <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      res_sum   <= '0;
      res_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            x_sh  <= i_x;
            y_sh  <= i_y;
            c_reg <= cin_load;
            cnt   <= '0;
            s_sh  <= '0;
          end
        end
        CALC: begin
          s_sh  <= s_next;
          x_sh  <= x_sh >> 1;
          y_sh  <= y_sh >> 1;
          c_reg <= fa_carry;
          cnt   <= cnt + 1'b1;
          // Result registers hold the last answer through IDLE until the next one completes.
          if (cnt == LAST) begin
            res_sum   <= s_next;
            res_carry <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sum     = res_sum;
  assign o_carry   = res_carry;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8) with hand-computed expected results.
// Subtract checks are included when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_x;
  logic [W-1:0] i_y;
  logic         i_carry;
`ifdef SERIAL_ADD_SUB_EN
  logic         i_sub;
`endif
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_sum;
  logic         o_carry;
  logic         o_busy;
  logic [1:0]   dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_carry   (i_carry),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub     (i_sub),
`endif
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sum     (o_sum),
    .o_carry   (o_carry),
    .o_busy    (o_busy),
    .dbg_state (dbg_state)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for o_valid with a bound; returns edges counted since the call.
  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic cin, input logic sub,
                        input logic [W-1:0] exp_sum, input logic exp_carry);
    int n;
    chk({tag, "_ready_before"}, 32'(o_ready), 32'd1);
    i_x = x; i_y = y; i_carry = cin; i_valid = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    i_sub = sub;
`endif
    step();
    i_valid = 1'b0;
    // Scramble inputs after acceptance; they must have no effect.
    i_x = ~x; i_y = ~y; i_carry = ~cin;
`ifdef SERIAL_ADD_SUB_EN
    i_sub = ~sub;
`endif
    wait_valid(n);
    chk({tag, "_latency"}, 32'(n), 32'(W));
    chk({tag, "_sum"}, 32'(o_sum), 32'(exp_sum));
    chk({tag, "_carry"}, 32'(o_carry), 32'(exp_carry));
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk({tag, "_ready_after"}, 32'(o_ready), 32'd1);
  endtask

  logic [W-1:0] vx [6] = '{8'h12, 8'hF0, 8'hAA, 8'h7F, 8'hC3, 8'h01};
  logic [W-1:0] vy [6] = '{8'h34, 8'h0F, 8'h55, 8'h01, 8'hC3, 8'hFE};
  logic         vc [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic [W-1:0] vs [6] = '{8'h46, 8'h00, 8'hFF, 8'h80, 8'h87, 8'h00};
  logic         vo [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};

  initial begin
    int n;
    int pulses;
    int prev_t;
    int t;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_x = '0; i_y = '0; i_carry = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    i_sub = 1'b0;
`endif
    step(); step();
    i_rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_sum",   32'(o_sum),   32'd0);
    chk("rst_carry", 32'(o_carry), 32'd0);

    // Basic add and carry propagation
    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    chk("idle_hold_sum", 32'(o_sum), 32'hFF);

    // Back-pressure: 80+80+1 = 101
    i_x = 8'h80; i_y = 8'h80; i_carry = 1'b1; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'(W));
    for (int k = 0; k < 5; k++) begin
      i_valid = k[0];
      i_x = 8'h11; i_y = 8'h22;
      step();
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_sum",   32'(o_sum),   32'h01);
      chk("bp_carry", 32'(o_carry), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    chk("bp_release_valid", 32'(o_valid), 32'd0);
    chk("bp_release_busy",  32'(o_busy),  32'd0);

    // Reset at the 4th CALC edge
    i_x = 8'h33; i_y = 8'h44; i_carry = 1'b0; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step(); step(); step();
    chk("mid_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy",  32'(o_busy),  32'd0);
    chk("mid_rst_sum",   32'(o_sum),   32'd0);
    pulses = 0;
    i_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_valid) pulses++;
    end
    i_ready = 1'b0;
    chk("mid_rst_no_result", 32'(pulses), 32'd0);

    // Back-to-back with i_valid and i_ready held high
    i_valid = 1'b1; i_ready = 1'b1;
    prev_t = 0;
    for (int i = 0; i < 6; i++) begin
      i_x = vx[i]; i_y = vy[i]; i_carry = vc[i];
      n = 0;
      while (!o_ready && n < 40) begin
        step();
        n++;
      end
      chk("b2b_ready_seen", 32'(o_ready), 32'd1);
      t = cyc;
      step();
      if (i > 0) chk("b2b_period", 32'(t - prev_t), 32'(W + 2));
      prev_t = t;
      wait_valid(n);
      chk("b2b_latency", 32'(n), 32'(W));
      chk("b2b_sum",     32'(o_sum),   32'(vs[i]));
      chk("b2b_carry",   32'(o_carry), 32'(vo[i]));
    end
    i_valid = 1'b0;
    step();
    i_ready = 1'b0;
    chk("b2b_end_idle", 32'(o_ready), 32'd1);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_op("sub0_add",  8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
